// File: rtl/osd_regaccess_master_if.sv
// dii_channel: one direction of a Debug Interconnect Infrastructure link.
//   data[15:0] - packet word
//   last       - marks the final word of a packet
//   valid      - word is presented by the sender
//   ready      - receiver accepts the word; a beat transfers when valid && ready
// The master modport sends packets and the slave modport receives them.
interface dii_channel;
   logic [15:0] data;
   logic        last;
   logic        valid;
   logic        ready;

   modport master (output data, output last, output valid, input ready);
   modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/osd_regaccess_master.sv
// osd_regaccess_master: turns a local register read/write request into a DI
// register-access packet and waits for the matching response packet.
// Ports:
//   clk, rst          - clock (rising edge) and asynchronous active-high reset
//   id                - own DI address: source of requests, destination of replies
//   req_valid/ready   - local request handshake
//   req_write         - 1 = write, 0 = read
//   req_dest/addr/wdata - target module, register address, write data
//   resp_valid        - one-cycle completion pulse
//   resp_error        - completion is an error (error reply or timeout)
//   resp_timeout      - completion caused by the response timeout
//   resp_rdata        - read data, updated only by a successful read
//   debug_out         - outgoing packet channel (master)
//   debug_in          - incoming packet channel (slave), always ready
// TIMEOUT_CYCLES: WAIT cycles before aborting; 0 disables the timeout.
module osd_regaccess_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       id,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [15:0]       req_dest,
   input  logic [15:0]       req_addr,
   input  logic [15:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_error,
   output logic              resp_timeout,
   output logic [15:0]       resp_rdata,
   dii_channel.master        debug_out,
   dii_channel.slave         debug_in
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [15:0] dest_q, dest_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [2:0]  wcnt_q, wcnt_d;
   logic [31:0] tcnt_q, tcnt_d;
   logic [2:0]  rx_cnt_q, rx_cnt_d;
   logic        rx_bad_q, rx_bad_d;
   logic [3:0]  rx_sub_q, rx_sub_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_error_q, resp_error_d;
   logic        resp_timeout_q, resp_timeout_d;
   logic [15:0] rdata_q, rdata_d;

   logic [15:0] out_word;
   logic        out_last;
   logic        out_hs;
   logic        in_hs;
   logic        beat_bad;
   logic        pkt_bad;
   logic [3:0]  sub_now;
   logic        rd_ok, rd_err, wr_ok, wr_err, accept;
   logic [31:0] tcnt_inc;
   logic        timeout_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         write_q        <= 1'b0;
         dest_q         <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         wcnt_q         <= '0;
         tcnt_q         <= '0;
         rx_cnt_q       <= '0;
         rx_bad_q       <= 1'b0;
         rx_sub_q       <= '0;
         resp_valid_q   <= 1'b0;
         resp_error_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         rdata_q        <= '0;
      end else begin
         state_q        <= state_d;
         write_q        <= write_d;
         dest_q         <= dest_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         wcnt_q         <= wcnt_d;
         tcnt_q         <= tcnt_d;
         rx_cnt_q       <= rx_cnt_d;
         rx_bad_q       <= rx_bad_d;
         rx_sub_q       <= rx_sub_d;
         resp_valid_q   <= resp_valid_d;
         resp_error_q   <= resp_error_d;
         resp_timeout_q <= resp_timeout_d;
         rdata_q        <= rdata_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      dest_d         = dest_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wcnt_d         = wcnt_q;
      tcnt_d         = tcnt_q;
      rx_cnt_d       = rx_cnt_q;
      rx_bad_d       = rx_bad_q;
      rx_sub_d       = rx_sub_q;
      resp_valid_d   = 1'b0;
      resp_error_d   = 1'b0;
      resp_timeout_d = 1'b0;
      rdata_d        = rdata_q;

      // Outgoing packet word selected by the beat counter.
      case (wcnt_q)
         3'd0:    out_word = dest_q;
         3'd1:    out_word = id;
         3'd2:    out_word = {2'b00, (write_q ? 4'h4 : 4'h0), 10'b0};
         3'd3:    out_word = addr_q;
         default: out_word = wdata_q;
      endcase
      out_last = write_q ? (wcnt_q == 3'd4) : (wcnt_q == 3'd3);
      out_hs   = (state_q == ST_SEND) && debug_out.ready;
      in_hs    = debug_in.valid && debug_in.ready;

      // Incoming packet checks. A packet is poisoned if any of its beats is
      // seen outside WAIT, so packets straddling a timeout or starting before
      // WAIT are always discarded.
      case (rx_cnt_q)
         3'd0:    beat_bad = (debug_in.data != id);
         3'd1:    beat_bad = (debug_in.data != dest_q);
         3'd2:    beat_bad = (debug_in.data[15:14] != 2'b00);
         default: beat_bad = 1'b0;
      endcase
      pkt_bad = rx_bad_q || beat_bad || (state_q != ST_WAIT);
      sub_now = (rx_cnt_q == 3'd2) ? debug_in.data[13:10] : rx_sub_q;

      // rx_cnt_q is the index of the current beat, so at the last beat
      // index 2 means a 3-word packet and index 3 a 4-word packet.
      rd_ok  = !write_q && (sub_now == 4'h8) && (rx_cnt_q == 3'd3);
      rd_err = !write_q && (sub_now == 4'hC) && (rx_cnt_q == 3'd2);
      wr_ok  = write_q  && (sub_now == 4'hD) && (rx_cnt_q == 3'd2);
      wr_err = write_q  && (sub_now == 4'hE) && (rx_cnt_q == 3'd2);
      accept = in_hs && debug_in.last && !pkt_bad &&
               (rd_ok || rd_err || wr_ok || wr_err);

      if (in_hs) begin
         if (debug_in.last) begin
            rx_cnt_d = '0;
            rx_bad_d = 1'b0;
         end else begin
            if (rx_cnt_q != 3'd7) begin
               rx_cnt_d = rx_cnt_q + 3'd1;
            end
            rx_bad_d = pkt_bad;
            if (rx_cnt_q == 3'd2) begin
               rx_sub_d = debug_in.data[13:10];
            end
         end
      end

      tcnt_inc    = tcnt_q + 32'd1;
      timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TIMEOUT_CYCLES);

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               dest_d  = req_dest;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wcnt_d  = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_hs) begin
               if (out_last) begin
                  tcnt_d  = '0;
                  state_d = ST_WAIT;
               end else begin
                  wcnt_d = wcnt_q + 3'd1;
               end
            end
         end
         ST_WAIT: begin
            // An accepted response wins over a timeout in the same cycle.
            if (accept) begin
               resp_valid_d = 1'b1;
               resp_error_d = rd_err || wr_err;
               if (rd_ok) begin
                  rdata_d = debug_in.data;
               end
               state_d = ST_IDLE;
            end else if (timeout_hit) begin
               resp_valid_d   = 1'b1;
               resp_error_d   = 1'b1;
               resp_timeout_d = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Ready outputs are gated by rst so they read 0 throughout reset.
   assign req_ready       = (state_q == ST_IDLE) && !rst;
   assign debug_in.ready  = !rst;
   assign debug_out.valid = (state_q == ST_SEND);
   assign debug_out.last  = (state_q == ST_SEND) && out_last;
   assign debug_out.data  = (state_q == ST_SEND) ? out_word : '0;
   assign resp_valid      = resp_valid_q;
   assign resp_error      = resp_error_q;
   assign resp_timeout    = resp_timeout_q;
   assign resp_rdata      = rdata_q;

endmodule

// File: tb/tb_osd_regaccess_master.sv
module tb_osd_regaccess_master;

   logic        clk;
   logic        rst;
   logic [15:0] id;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_dest;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_error;
   logic        resp_timeout;
   logic [15:0] resp_rdata;

   dii_channel dout ();
   dii_channel din ();

   osd_regaccess_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .id           (id),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_dest     (req_dest),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_error   (resp_error),
      .resp_timeout (resp_timeout),
      .resp_rdata   (resp_rdata),
      .debug_out    (dout),
      .debug_in     (din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp;
   int unsigned n_err;

   logic [15:0] got_w [8];
   logic        got_l [8];
   int unsigned got_n;
   logic [15:0] pkt [8];

   typedef struct {
      logic        wr;
      logic [15:0] dest;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        stall;
      int unsigned en;
      logic [15:0] ew [5];
      int unsigned rn;
      logic [15:0] rw [5];
      logic        exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic wr, input logic [15:0] dest,
                         input logic [15:0] addr, input logic [15:0] wdata);
      req_write = wr;
      req_dest  = dest;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      req_dest  = 16'hFFFF;
      req_addr  = 16'hFFFF;
      req_wdata = 16'hFFFF;
   endtask

   // Accepts outgoing words; with stall set, ready is low on even cycles.
   task automatic collect(input logic stall);
      logic        done;
      logic        pv;
      logic [15:0] pd;
      logic        pl;
      int unsigned cyc;
      done  = 1'b0;
      pv    = 1'b0;
      pd    = '0;
      pl    = 1'b0;
      cyc   = 0;
      got_n = 0;
      while (!done && cyc < 60) begin
         dout.ready = stall ? ((cyc % 2) == 1) : 1'b1;
         #0;
         if (dout.valid) begin
            if (pv) begin
               chk("stall_data", {16'b0, dout.data}, {16'b0, pd});
               chk("stall_last", {31'b0, dout.last}, {31'b0, pl});
            end
            if (dout.ready) begin
               if (got_n < 8) begin
                  got_w[got_n] = dout.data;
                  got_l[got_n] = dout.last;
               end
               got_n++;
               if (dout.last) done = 1'b1;
               pv = 1'b0;
            end else begin
               pv = 1'b1;
               pd = dout.data;
               pl = dout.last;
            end
         end
         step();
         cyc++;
      end
      dout.ready = 1'b1;
      chk("packet_done", {31'b0, done}, 32'd1);
      chk("valid_drop", {31'b0, dout.valid}, 32'd0);
   endtask

   task automatic send_pkt(input int unsigned n, input logic quiet);
      for (int unsigned i = 0; i < n; i++) begin
         din.valid = 1'b1;
         din.data  = pkt[i];
         din.last  = (i == n - 1);
         step();
         if (quiet) chk("no_resp_filtered", {31'b0, resp_valid}, 32'd0);
      end
      din.valid = 1'b0;
      din.last  = 1'b0;
      din.data  = '0;
   endtask

   task automatic check_words(input int unsigned en, input logic [15:0] ew [5]);
      chk("word_count", got_n, en);
      for (int unsigned k = 0; k < en && k < got_n; k++) begin
         chk("out_word", {16'b0, got_w[k]}, {16'b0, ew[k]});
         chk("out_last", {31'b0, got_l[k]}, {31'b0, (k == en - 1)});
      end
   endtask

   task automatic check_done(input logic err, input logic tmo, input logic [15:0] rdata);
      chk("resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("resp_error", {31'b0, resp_error}, {31'b0, err});
      chk("resp_timeout", {31'b0, resp_timeout}, {31'b0, tmo});
      chk("resp_rdata", {16'b0, resp_rdata}, {16'b0, rdata});
      step();
      chk("resp_pulse_end", {31'b0, resp_valid}, 32'd0);
      chk("resp_error_clr", {31'b0, resp_error}, 32'd0);
      chk("req_ready_after", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned first;
      logic [15:0] rd_exp;

      n_cmp = 0;
      n_err = 0;
      rst        = 1'b1;
      id         = 16'h0001;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_dest   = '0;
      req_addr   = '0;
      req_wdata  = '0;
      dout.ready = 1'b1;
      din.valid  = 1'b0;
      din.last   = 1'b0;
      din.data   = '0;

      vecs[0] = '{wr:1'b0, dest:16'h0005, addr:16'h0200, wdata:16'h0000, stall:1'b0,
                  en:4, ew:'{16'h0005, 16'h0001, 16'h0000, 16'h0200, 16'h0000},
                  rn:4, rw:'{16'h0001, 16'h0005, 16'h2000, 16'hCAFE, 16'h0000},
                  exp_err:1'b0, exp_rdata:16'hCAFE};
      vecs[1] = '{wr:1'b1, dest:16'h0005, addr:16'h0201, wdata:16'h1234, stall:1'b1,
                  en:5, ew:'{16'h0005, 16'h0001, 16'h1000, 16'h0201, 16'h1234},
                  rn:3, rw:'{16'h0001, 16'h0005, 16'h3400, 16'h0000, 16'h0000},
                  exp_err:1'b0, exp_rdata:16'hCAFE};
      vecs[2] = '{wr:1'b0, dest:16'h0005, addr:16'h0300, wdata:16'h0000, stall:1'b0,
                  en:4, ew:'{16'h0005, 16'h0001, 16'h0000, 16'h0300, 16'h0000},
                  rn:3, rw:'{16'h0001, 16'h0005, 16'h3000, 16'h0000, 16'h0000},
                  exp_err:1'b1, exp_rdata:16'hCAFE};
      vecs[3] = '{wr:1'b1, dest:16'h0009, addr:16'h0010, wdata:16'hA5A5, stall:1'b0,
                  en:5, ew:'{16'h0009, 16'h0001, 16'h1000, 16'h0010, 16'hA5A5},
                  rn:3, rw:'{16'h0001, 16'h0009, 16'h3800, 16'h0000, 16'h0000},
                  exp_err:1'b1, exp_rdata:16'hCAFE};
      vecs[4] = '{wr:1'b0, dest:16'h0009, addr:16'h00FF, wdata:16'h0000, stall:1'b1,
                  en:4, ew:'{16'h0009, 16'h0001, 16'h0000, 16'h00FF, 16'h0000},
                  rn:4, rw:'{16'h0001, 16'h0009, 16'h2000, 16'h5A5A, 16'h0000},
                  exp_err:1'b0, exp_rdata:16'h5A5A};

      // Reset state
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
      chk("rst_resp_timeout", {31'b0, resp_timeout}, 32'd0);
      chk("rst_resp_rdata", {16'b0, resp_rdata}, 32'd0);
      chk("rst_out_valid", {31'b0, dout.valid}, 32'd0);
      chk("rst_out_last", {31'b0, dout.last}, 32'd0);
      chk("rst_out_data", {16'b0, dout.data}, 32'd0);
      chk("rst_in_ready", {31'b0, din.ready}, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);
      chk("in_ready_run", {31'b0, din.ready}, 32'd1);

      // Table-driven transactions
      for (int unsigned v = 0; v < 5; v++) begin
         do_req(vecs[v].wr, vecs[v].dest, vecs[v].addr, vecs[v].wdata);
         collect(vecs[v].stall);
         check_words(vecs[v].en, vecs[v].ew);
         for (int unsigned k = 0; k < 5; k++) pkt[k] = vecs[v].rw[k];
         send_pkt(vecs[v].rn, 1'b0);
         check_done(vecs[v].exp_err, 1'b0, vecs[v].exp_rdata);
      end
      rd_exp = 16'h5A5A;

      // Filtering: wrong source, then wrong length, then a correct reply
      do_req(1'b0, 16'h0005, 16'h0400, 16'h0000);
      collect(1'b0);
      pkt[0] = 16'h0001; pkt[1] = 16'h0007; pkt[2] = 16'h2000; pkt[3] = 16'hDEAD;
      send_pkt(4, 1'b1);
      pkt[0] = 16'h0001; pkt[1] = 16'h0005; pkt[2] = 16'h2000; pkt[3] = 16'hBEEF;
      pkt[4] = 16'h1111;
      send_pkt(5, 1'b1);
      chk("filtered_rdata_kept", {16'b0, resp_rdata}, {16'b0, rd_exp});
      pkt[0] = 16'h0001; pkt[1] = 16'h0005; pkt[2] = 16'h2000; pkt[3] = 16'h7777;
      send_pkt(4, 1'b0);
      check_done(1'b0, 1'b0, 16'h7777);

      // Timeout with no reply: pulse 16 cycles after entering WAIT
      do_req(1'b0, 16'h0005, 16'h0500, 16'h0000);
      collect(1'b0);
      first = 0;
      for (int unsigned k = 1; k <= 40; k++) begin
         step();
         if (resp_valid) begin
            first = k;
            break;
         end
      end
      chk("timeout_cycles", first, 32'd16);
      check_done(1'b1, 1'b1, 16'h7777);

      // Reply whose last beat coincides with the timeout wins
      do_req(1'b0, 16'h0005, 16'h0600, 16'h0000);
      collect(1'b0);
      repeat (12) step();
      pkt[0] = 16'h0001; pkt[1] = 16'h0005; pkt[2] = 16'h2000; pkt[3] = 16'h600D;
      send_pkt(4, 1'b0);
      check_done(1'b0, 1'b0, 16'h600D);

      // Reset in the middle of a write packet
      req_write = 1'b1;
      req_dest  = 16'h0005;
      req_addr  = 16'h0700;
      req_wdata = 16'h9999;
      req_valid = 1'b1;
      step();
      req_valid  = 1'b0;
      dout.ready = 1'b1;
      step();
      step();
      chk("pre_rst_valid", {31'b0, dout.valid}, 32'd1);
      chk("pre_rst_data", {16'b0, dout.data}, 32'h0000_1000);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", {31'b0, dout.valid}, 32'd0);
      chk("rst_mid_data", {16'b0, dout.data}, 32'd0);
      chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd0);
      step();
      chk("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
      #3;
      rst = 1'b0;
      step();
      chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rel_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rel_out_valid", {31'b0, dout.valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
